clb_config_loader: RTL and testbench
====================================

// Module: clb_config_loader
// PURPOSE
//  Serial configuration loader for one CLB. It sits directly upstream of the logic_pair
//  instances and drives their look_up_t, switch and CLB_prgm_b inputs.
//  - Shifts a parity-protected bitstream into a shadow register.
//  - Commits the whole shadow to the active config in one cycle.
//  - Logic pairs never see a partial or corrupt configuration.
// PARAMETERS
//  N_PAIRS  4   number of logic pairs served; frame = N_PAIRS*17 payload bits + 1 parity bit
// PORTS
//  clk         in   1          system clock; all state updates on rising edge
//  reset       in   1          asynchronous, active-high reset
//  prgm_b      in   1          global program strobe, active low; falling edge starts a load
//  bit_in      in   1          serial config bit
//  bit_valid   in   1          bit_in valid; bit accepted when bit_valid & bit_ready
//  bit_ready   out  1          loader can accept a bit (LOAD/PARITY states only)
//  look_up_t   out  16*N_PAIRS active LUT contents; pair k = look_up_t[16k +: 16]
//  switch      out  N_PAIRS    active FF/LUT mux select; pair k = switch[k]
//  CLB_prgm_b  out  1          low while config is being rewritten; high when stable
//  done        out  1          last load committed successfully
//  err         out  1          last load failed (parity mismatch or abort)
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE; shadow, look_up_t and switch = 0.
//   - CLB_prgm_b=1, done=0, err=0, bit_ready=0, prgm_q=1, bit count=0, parity acc=0.
//  Start:
//   - prgm_q is prgm_b registered; start = prgm_q & ~prgm_b.
//   - Honoured in IDLE, DONE and ERROR: -> LOAD; clear count, parity acc, done and err;
//     CLB_prgm_b<=0.
//  LOAD (bit_ready=1), on each accepted bit:
//   - shadow <= {shadow[TOTAL-2:0], bit_in}; acc <= acc ^ bit_in; count++.
//   - Accepting bit number TOTAL-1 (count==TOTAL-1) -> PARITY.
//   - Cycles with bit_valid=0: no change.
//  Bit order: the first bit lands at shadow[TOTAL-1], so the stream is
//   switch[N-1], LUT[N-1][15..0], ..., switch[0], LUT[0][15..0], parity.
//   Pair k: LUT = shadow[17k +: 16], switch = shadow[17k+16].
//  PARITY (bit_ready=1), on the accepted bit (even parity; payload ^ parity = 0):
//   - bit_in == acc -> COMMIT.
//   - Otherwise -> ERROR with err<=1, CLB_prgm_b<=1; active config untouched.
//  COMMIT (bit_ready=0), one cycle:
//   - look_up_t/switch <= shadow; done<=1; CLB_prgm_b<=1 on the same edge; -> DONE.
//   - Latency: parity bit accepted at edge t; new outputs, done=1 and CLB_prgm_b=1
//     visible after edge t+1.
//  DONE/ERROR: hold all outputs; bit_ready=0; leave only on start.
//  Abort: prgm_b sampled high while in LOAD/PARITY -> IDLE, err<=1, CLB_prgm_b<=1;
//   shadow discarded, active config unchanged.
//  Priority: abort beats bit acceptance in the same cycle.
//  Async reset mid-load: everything returns to reset values, including active config.
//  Count width = $clog2(TOTAL+1); no wrap, because count clears on every start.
// STRUCTURE
//  Package clb_cfg_pkg:
//   - LUT_W=16, PAIR_W=17.
//   - State enum IDLE/LOAD/PARITY/COMMIT/DONE/ERROR, 3-bit encoding.
//  Sub-module cfg_shift_reg (WIDTH param):
//   - shift-enable, serial in, parallel out, running XOR parity, synchronous clear.
//  The top holds the FSM, start-edge detect, bit counter and active config registers.
// TESTING (N_PAIRS=2, TOTAL=34)
//  1 Reset at time 0 -> look_up_t=0, switch=0, CLB_prgm_b=1, done=0, err=0, bit_ready=0.
//  2 Good load:
//     - Stimulus: start, stream sw1=1, LUT1=16'h6996, sw0=0, LUT0=16'h8000, parity=0.
//     - Response: one cycle after the parity bit, look_up_t=32'h6996_8000, switch=2'b10,
//       done=1, CLB_prgm_b=1.
//     - CLB_prgm_b stays low from the cycle after start until that commit edge.
//  3 Same stream, parity=1 -> err=1, done=0; look_up_t/switch keep the previous values.
//  4 Load from test 2 with bit_valid low on random cycles (~40%) -> final state identical
//    to test 2; no bits accepted in COMMIT/DONE.
//  5 prgm_b back high after 10 accepted bits -> next cycle: IDLE, err=1, CLB_prgm_b=1,
//    outputs unchanged. A new falling edge then reloads cleanly.
//  6 reset pulsed mid-LOAD between clock edges -> outputs reach reset values before the
//    next edge; the first start after reset loads correctly.

Source files
------------

// File: rtl/clb_cfg_pkg.sv
// Shared widths and FSM state encoding for the CLB configuration loader.
package clb_cfg_pkg;

    localparam int unsigned LUT_W  = 16;
    localparam int unsigned PAIR_W = 17;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PARITY = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } cfg_state_e;

endpackage

// File: rtl/cfg_shift_reg.sv
// Shadow shift register: serial in, parallel out, running XOR of shifted bits.
module cfg_shift_reg #(
    parameter int unsigned WIDTH = 68
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic             parity
);

    // Shift toward the MSB so the first bit ends up at par_out[WIDTH-1]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_out <= '0;
            parity  <= 1'b0;
        end else if (clr) begin
            par_out <= '0;
            parity  <= 1'b0;
        end else if (shift_en) begin
            par_out <= {par_out[WIDTH-2:0], ser_in};
            parity  <= parity ^ ser_in;
        end
    end

endmodule

// File: rtl/clb_config_loader.sv
// Serial, parity-protected configuration loader for one CLB; the active config
// changes only in a single commit cycle after a clean frame.
module clb_config_loader
    import clb_cfg_pkg::*;
#(
    parameter int unsigned N_PAIRS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       prgm_b,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    output logic [LUT_W*N_PAIRS-1:0]   look_up_t,
    output logic [N_PAIRS-1:0]         switch,
    output logic                       CLB_prgm_b,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned TOTAL = N_PAIRS * PAIR_W;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

    cfg_state_e               state;
    cfg_state_e               state_nxt;
    logic                     prgm_q;
    logic [CNT_W-1:0]         cnt;
    logic [TOTAL-1:0]         shadow;
    logic                     acc;

    logic                     start_c;
    logic                     accept_c;
    logic                     shift_en_c;
    logic                     clr_c;
    logic                     commit_c;
    logic                     done_nxt;
    logic                     err_nxt;
    logic                     prgm_out_nxt;
    logic [LUT_W*N_PAIRS-1:0] lut_c;
    logic [N_PAIRS-1:0]       sw_c;

    cfg_shift_reg #(
        .WIDTH (TOTAL)
    ) u_shadow (
        .clk      (clk),
        .rst      (reset),
        .clr      (clr_c),
        .shift_en (shift_en_c),
        .ser_in   (bit_in),
        .par_out  (shadow),
        .parity   (acc)
    );

    // Next-state and control decode; abort has priority over bit acceptance
    always_comb begin
        state_nxt    = state;
        shift_en_c   = 1'b0;
        clr_c        = 1'b0;
        commit_c     = 1'b0;
        done_nxt     = done;
        err_nxt      = err;
        prgm_out_nxt = CLB_prgm_b;
        start_c      = prgm_q & ~prgm_b;
        accept_c     = bit_valid & bit_ready;

        case (state)
            IDLE, DONE, ERROR: begin
                if (start_c) begin
                    state_nxt    = LOAD;
                    clr_c        = 1'b1;
                    done_nxt     = 1'b0;
                    err_nxt      = 1'b0;
                    prgm_out_nxt = 1'b0;
                end
            end
            LOAD: begin
                if (prgm_b) begin
                    state_nxt    = IDLE;
                    err_nxt      = 1'b1;
                    prgm_out_nxt = 1'b1;
                end else if (accept_c) begin
                    shift_en_c = 1'b1;
                    if (cnt == CNT_W'(TOTAL - 1)) begin
                        state_nxt = PARITY;
                    end
                end
            end
            PARITY: begin
                if (prgm_b) begin
                    state_nxt    = IDLE;
                    err_nxt      = 1'b1;
                    prgm_out_nxt = 1'b1;
                end else if (accept_c) begin
                    if (bit_in == acc) begin
                        state_nxt = COMMIT;
                    end else begin
                        state_nxt    = ERROR;
                        err_nxt      = 1'b1;
                        prgm_out_nxt = 1'b1;
                    end
                end
            end
            COMMIT: begin
                commit_c     = 1'b1;
                done_nxt     = 1'b1;
                prgm_out_nxt = 1'b1;
                state_nxt    = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Unpack the shadow frame into per-pair LUT and switch fields
    always_comb begin
        lut_c = '0;
        sw_c  = '0;
        for (int k = 0; k < int'(N_PAIRS); k++) begin
            lut_c[LUT_W*k +: LUT_W] = shadow[PAIR_W*k +: LUT_W];
            sw_c[k]                 = shadow[PAIR_W*k + LUT_W];
        end
    end

    // FSM state, start-edge history and bit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            prgm_q <= 1'b1;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            prgm_q <= prgm_b;
            if (clr_c) begin
                cnt <= '0;
            end else if (shift_en_c) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_ready  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            CLB_prgm_b <= 1'b1;
        end else begin
            bit_ready  <= (state_nxt == LOAD) || (state_nxt == PARITY);
            done       <= done_nxt;
            err        <= err_nxt;
            CLB_prgm_b <= prgm_out_nxt;
        end
    end

    // Active configuration, replaced only on commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            look_up_t <= '0;
            switch    <= '0;
        end else if (commit_c) begin
            look_up_t <= lut_c;
            switch    <= sw_c;
        end
    end

endmodule

// File: tb/tb_clb_config_loader.sv
// Bench for clb_config_loader with two logic pairs (34 payload bits + parity).
module tb_clb_config_loader;

    localparam int unsigned NP    = 2;
    localparam int unsigned FRAME = NP * 17 + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              prgm_b;
    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic [16*NP-1:0]  look_up_t;
    logic [NP-1:0]     switch;
    logic              CLB_prgm_b;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    // Reference model: the configuration the logic pairs should currently see
    logic [31:0] m_lut;
    logic [1:0]  m_sw;

    clb_config_loader #(.N_PAIRS(NP)) dut (
        .clk        (clk),
        .reset      (reset),
        .prgm_b     (prgm_b),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .look_up_t  (look_up_t),
        .switch     (switch),
        .CLB_prgm_b (CLB_prgm_b),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] lut1;
        logic [15:0] lut0;
        logic [1:0]  sw;
        logic        corrupt;
        int unsigned drop_pct;
        logic [31:0] exp_lut;
        logic [1:0]  exp_sw;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [31:0] e_lut, input logic [1:0] e_sw,
                             input logic e_done, input logic e_err);
        check({name, ".look_up_t"}, 64'(look_up_t), 64'(e_lut));
        check({name, ".switch"},    64'(switch),    64'(e_sw));
        check({name, ".done"},      64'(done),      64'(e_done));
        check({name, ".err"},       64'(err),       64'(e_err));
        check({name, ".CLB_prgm_b"}, 64'(CLB_prgm_b), 64'(1));
        check({name, ".bit_ready"}, 64'(bit_ready), 64'(0));
    endtask

    function automatic logic [FRAME-1:0] build_frame(input logic [15:0] l1, input logic [15:0] l0,
                                                     input logic [1:0] sw, input logic corrupt);
        logic [FRAME-2:0] payload;
        payload = {sw[1], l1, sw[0], l0};
        return {payload, (^payload) ^ corrupt};
    endfunction

    // Produce a falling edge on prgm_b, which the loader sees on the following clock edge
    task automatic start_load();
        @(negedge clk);
        prgm_b    = 1'b1;
        bit_valid = 1'b0;
        @(negedge clk);
        prgm_b = 1'b0;
    endtask

    // Stream the first nbits of a frame MSB-first with random idle cycles
    task automatic send_bits(input string name, input logic [FRAME-1:0] frame, input int nbits,
                             input int unsigned drop_pct);
        int  idx    = 0;
        int  cyc    = 0;
        bit  low_ok = 1'b1;
        while (idx < nbits && cyc < 400) begin
            @(negedge clk);
            if (CLB_prgm_b !== 1'b0) low_ok = 1'b0;
            bit_valid = ($urandom_range(99) >= drop_pct);
            bit_in    = frame[FRAME-1-idx];
            if (bit_valid && bit_ready) idx++;
            cyc++;
        end
        check({name, ".timeout"}, 64'(cyc < 400), 64'(1));
        check({name, ".prgm_low_during_load"}, 64'(low_ok), 64'(1));
    endtask

    // Full load; returns at the negedge after the commit edge
    task automatic run_frame(input string name, input logic [15:0] l1, input logic [15:0] l0,
                             input logic [1:0] sw, input logic corrupt, input int unsigned drop_pct);
        start_load();
        send_bits(name, build_frame(l1, l0, sw, corrupt), FRAME, drop_pct);
        @(negedge clk);
        bit_valid = 1'b0;
        if (!corrupt) begin
            check({name, ".prgm_before_commit"}, 64'(CLB_prgm_b), 64'(0));
            check({name, ".done_before_commit"}, 64'(done), 64'(0));
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[6];
        bit   rdy_ok;
        logic [15:0] r1, r0;
        logic [1:0]  rs;
        logic        rc;

        vecs[0] = '{16'h6996, 16'h8000, 2'b10, 1'b0, 0,  32'h6996_8000, 2'b10, 1'b1, 1'b0};
        vecs[1] = '{16'h6996, 16'h8000, 2'b10, 1'b1, 0,  32'h6996_8000, 2'b10, 1'b0, 1'b1};
        vecs[2] = '{16'h6996, 16'h8000, 2'b10, 1'b0, 40, 32'h6996_8000, 2'b10, 1'b1, 1'b0};
        vecs[3] = '{16'hA5A5, 16'h0001, 2'b01, 1'b0, 20, 32'hA5A5_0001, 2'b01, 1'b1, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 2'b11, 1'b1, 10, 32'hA5A5_0001, 2'b01, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 2'b00, 1'b0, 40, 32'h0000_0000, 2'b00, 1'b1, 1'b0};

        reset     = 1'b1;
        prgm_b    = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        m_lut     = '0;
        m_sw      = '0;
        #1;
        check_out("reset", 32'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].lut1, vecs[i].lut0, vecs[i].sw,
                      vecs[i].corrupt, vecs[i].drop_pct);
            check_out($sformatf("vec%0d", i), vecs[i].exp_lut, vecs[i].exp_sw,
                      vecs[i].exp_done, vecs[i].exp_err);
            m_lut = vecs[i].exp_lut;
            m_sw  = vecs[i].exp_sw;
            if (i == 2) begin
                rdy_ok = 1'b1;
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    if (bit_ready !== 1'b0) rdy_ok = 1'b0;
                    bit_valid = 1'b1;
                    bit_in    = 1'($urandom_range(1));
                end
                @(negedge clk);
                bit_valid = 1'b0;
                check("done_no_accept", 64'(rdy_ok), 64'(1));
                check_out("done_hold", m_lut, m_sw, 1'b1, 1'b0);
            end
        end

        for (int i = 0; i < 8; i++) begin
            r1 = 16'($urandom);
            r0 = 16'($urandom);
            rs = 2'($urandom_range(3));
            rc = ($urandom_range(3) == 0);
            run_frame($sformatf("rand%0d", i), r1, r0, rs, rc, $urandom_range(40));
            if (!rc) begin
                m_lut = {r1, r0};
                m_sw  = rs;
            end
            check_out($sformatf("rand%0d", i), m_lut, m_sw, !rc, rc);
        end

        // Abort after 10 accepted bits, then reload cleanly
        start_load();
        send_bits("abort", build_frame(16'h1234, 16'h5678, 2'b11, 1'b0), 10, 0);
        @(negedge clk);
        bit_valid = 1'b0;
        prgm_b    = 1'b1;
        @(negedge clk);
        check_out("abort", m_lut, m_sw, 1'b0, 1'b1);
        run_frame("reload", 16'h6996, 16'h8000, 2'b10, 1'b0, 0);
        m_lut = 32'h6996_8000;
        m_sw  = 2'b10;
        check_out("reload", m_lut, m_sw, 1'b1, 1'b0);

        // Asynchronous reset between clock edges in the middle of a load
        start_load();
        send_bits("midreset", build_frame(16'hBEEF, 16'hCAFE, 2'b01, 1'b0), 5, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_out("midreset", 32'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        reset     = 1'b0;
        bit_valid = 1'b0;
        m_lut     = '0;
        m_sw      = '0;
        run_frame("post_reset", 16'hBEEF, 16'hCAFE, 2'b01, 1'b0, 25);
        check_out("post_reset", 32'hBEEF_CAFE, 2'b01, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
